// File: rtl/imem_fetch_port_if.sv
// Fetch-side request/response bundle between the fetch stage (master) and the
// instruction memory (slave).
interface imem_fetch_port_if #(
  parameter int unsigned PC_W        = 64,
  parameter int unsigned FETCH_BYTES = 10
) ();
  localparam int unsigned REST_W = 8 * (FETCH_BYTES - 1);

  logic              req_valid;
  logic [PC_W-1:0]   req_pc;
  logic              req_ready;
  logic              rsp_valid;
  logic              rsp_ready;
  logic [7:0]        rsp_byte0;
  logic [REST_W-1:0] rsp_rest;
  logic              rsp_error;

  modport master (
    output req_valid, req_pc, rsp_ready,
    input  req_ready, rsp_valid, rsp_byte0, rsp_rest, rsp_error
  );

  modport slave (
    input  req_valid, req_pc, rsp_ready,
    output req_ready, rsp_valid, rsp_byte0, rsp_rest, rsp_error
  );
endinterface

// File: rtl/imem_fetch_port.sv
// Byte-addressed Y86 instruction memory with a byte-serial program loader and a
// single-entry valid/ready fetch port that flags any out-of-range fetch window.
module imem_fetch_port #(
  parameter int unsigned ADDR_W      = 11,
  parameter int unsigned PC_W        = 64,
  parameter int unsigned FETCH_BYTES = 10
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            load_start_i,
  input  logic [PC_W-1:0] load_addr_i,
  input  logic            load_valid_i,
  input  logic [7:0]      load_byte_i,
  input  logic            load_done_i,
  output logic            load_error_o,
  output logic            run_o,
  imem_fetch_port_if.slave fetch
);
  localparam int unsigned DEPTH  = 2 ** ADDR_W;
  localparam int unsigned REST_W = 8 * (FETCH_BYTES - 1);
  localparam logic [PC_W-1:0] LAST_PC = PC_W'(DEPTH - FETCH_BYTES);

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_LOAD = 2'd1;
  localparam logic [1:0] ST_RUN  = 2'd2;

  logic [7:0]        mem_q [DEPTH];
  logic [1:0]        state_q, state_d;
  logic              run_q, run_d;
  logic [PC_W-1:0]   cnt_q, cnt_d;
  logic              load_err_q, load_err_d;
  logic              rsp_valid_q, rsp_valid_d;
  logic              rsp_error_q, rsp_error_d;
  logic [7:0]        rsp_byte0_q, rsp_byte0_d;
  logic [REST_W-1:0] rsp_rest_q, rsp_rest_d;

  logic              load_wr_c;
  logic              cnt_in_range_c;
  logic              accept_c;
  logic              win_err_c;
  logic [ADDR_W-1:0] base_c;
  logic [7:0]        rd_byte0_c;
  logic [REST_W-1:0] rd_rest_c;

  // State register and all registered outputs
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= ST_IDLE;
      run_q       <= 1'b0;
      cnt_q       <= '0;
      load_err_q  <= 1'b0;
      rsp_valid_q <= 1'b0;
      rsp_error_q <= 1'b0;
      rsp_byte0_q <= '0;
      rsp_rest_q  <= '0;
    end else begin
      state_q     <= state_d;
      run_q       <= run_d;
      cnt_q       <= cnt_d;
      load_err_q  <= load_err_d;
      rsp_valid_q <= rsp_valid_d;
      rsp_error_q <= rsp_error_d;
      rsp_byte0_q <= rsp_byte0_d;
      rsp_rest_q  <= rsp_rest_d;
    end
  end

  // Storage is deliberately not cleared by reset
  always_ff @(posedge clk) begin
    if (!rst && load_wr_c && cnt_in_range_c) begin
      mem_q[cnt_q[ADDR_W-1:0]] <= load_byte_i;
    end
  end

  // Next-state, loader and response logic
  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    load_err_d  = load_err_q;
    rsp_valid_d = rsp_valid_q;
    rsp_error_d = rsp_error_q;
    rsp_byte0_d = rsp_byte0_q;
    rsp_rest_d  = rsp_rest_q;

    case (state_q)
      ST_IDLE: if (load_start_i) state_d = ST_LOAD;
      ST_LOAD: begin
        if (load_start_i)     state_d = ST_LOAD;
        else if (load_done_i) state_d = ST_RUN;
      end
      ST_RUN:  if (load_start_i) state_d = ST_LOAD;
      default: state_d = ST_IDLE;
    endcase
    run_d = (state_d == ST_RUN);

    // A simultaneous load_start restarts the loader and discards the byte
    if (load_start_i) begin
      cnt_d      = load_addr_i;
      load_err_d = 1'b0;
    end else if (load_wr_c) begin
      if (cnt_q != '1) cnt_d = cnt_q + PC_W'(1);
      if (!cnt_in_range_c) load_err_d = 1'b1;
    end

    // Leaving RUN drops any pending response, even one accepted this cycle
    if (run_q && load_start_i) begin
      rsp_valid_d = 1'b0;
    end else if (accept_c) begin
      rsp_valid_d = 1'b1;
      rsp_error_d = win_err_c;
      rsp_byte0_d = win_err_c ? 8'h00 : rd_byte0_c;
      rsp_rest_d  = win_err_c ? '0 : rd_rest_c;
    end else if (fetch.rsp_ready) begin
      rsp_valid_d = 1'b0;
    end
  end

  assign load_wr_c      = (state_q == ST_LOAD) && load_valid_i && !load_start_i;
  assign cnt_in_range_c = ~|cnt_q[PC_W-1:ADDR_W];
  assign accept_c       = fetch.req_valid && fetch.req_ready;
  assign win_err_c      = fetch.req_pc > LAST_PC;
  assign base_c         = fetch.req_pc[ADDR_W-1:0];

  // Window read; wrapped indices only occur on error fetches, whose data is zeroed
  always_comb begin
    rd_byte0_c = mem_q[base_c];
    rd_rest_c  = '0;
    for (int j = 1; j < int'(FETCH_BYTES); j++) begin
      rd_rest_c[8*(int'(FETCH_BYTES)-j)-1 -: 8] = mem_q[base_c + ADDR_W'(j)];
    end
  end

  assign fetch.req_ready = run_q && (!rsp_valid_q || fetch.rsp_ready);
  assign fetch.rsp_valid = rsp_valid_q;
  assign fetch.rsp_error = rsp_error_q;
  assign fetch.rsp_byte0 = rsp_byte0_q;
  assign fetch.rsp_rest  = rsp_rest_q;
  assign load_error_o    = load_err_q;
  assign run_o           = run_q;
endmodule

// File: tb/tb_imem_fetch_port.sv
// Directed bench for imem_fetch_port: fetch-vector table plus hand sequences
// for stall, load overflow, state gating and reset mid-operation.
module tb_imem_fetch_port;
  localparam int unsigned ADDR_W = 11;
  localparam int unsigned PC_W   = 64;
  localparam int unsigned FB     = 10;
  localparam int unsigned REST_W = 8 * (FB - 1);

  typedef struct {
    logic [PC_W-1:0]   pc;
    logic              exp_err;
    logic [7:0]        exp_b0;
    logic [REST_W-1:0] exp_rest;
  } vec_t;

  logic            clk = 1'b0;
  logic            rst;
  logic            load_start, load_valid, load_done, load_error, run;
  logic [PC_W-1:0] load_addr;
  logic [7:0]      load_byte;

  logic [7:0] model [2048];
  vec_t       vecs [9];
  int         n_checks = 0;
  int         n_fail   = 0;

  imem_fetch_port_if #(.PC_W(PC_W), .FETCH_BYTES(FB)) fif ();

  imem_fetch_port #(.ADDR_W(ADDR_W), .PC_W(PC_W), .FETCH_BYTES(FB)) dut (
    .clk          (clk),
    .rst          (rst),
    .load_start_i (load_start),
    .load_addr_i  (load_addr),
    .load_valid_i (load_valid),
    .load_byte_i  (load_byte),
    .load_done_i  (load_done),
    .load_error_o (load_error),
    .run_o        (run),
    .fetch        (fif.slave)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic push_byte(input int addr, input logic [7:0] b);
    load_valid = 1'b1;
    load_byte  = b;
    if (addr < 2048) model[addr] = b;
    step();
    load_valid = 1'b0;
  endtask

  function automatic logic [REST_W-1:0] model_rest(input int pc);
    logic [REST_W-1:0] r;
    r = '0;
    for (int j = 1; j < int'(FB); j++) r[8*(int'(FB)-j)-1 -: 8] = model[pc+j];
    return r;
  endfunction

  task automatic chk_rsp(input string name, input logic err, input logic [7:0] b0,
                         input logic [REST_W-1:0] rest);
    chk({name, "_valid"}, 128'(fif.rsp_valid), 128'(1'b1));
    chk({name, "_err"},   128'(fif.rsp_error), 128'(err));
    chk({name, "_b0"},    128'(fif.rsp_byte0), 128'(b0));
    chk({name, "_rest"},  128'(fif.rsp_rest),  128'(rest));
  endtask

  initial begin
    logic [7:0] prog [10];
    prog = '{8'h30, 8'hF8, 8'h04, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00};
    for (int i = 0; i < 2048; i++) model[i] = 8'h00;

    rst = 1'b1; load_start = 1'b0; load_valid = 1'b0; load_done = 1'b0;
    load_addr = '0; load_byte = '0;
    fif.req_valid = 1'b0; fif.req_pc = '0; fif.rsp_ready = 1'b0;
    step(); step();
    chk("rst_run",       128'(run),           128'(0));
    chk("rst_rsp_valid", 128'(fif.rsp_valid), 128'(0));
    chk("rst_rsp_error", 128'(fif.rsp_error), 128'(0));
    chk("rst_load_err",  128'(load_error),    128'(0));
    chk("rst_byte0",     128'(fif.rsp_byte0), 128'(0));
    chk("rst_rest",      128'(fif.rsp_rest),  128'(0));
    rst = 1'b0;

    // Requests are refused in IDLE and in LOAD
    fif.req_valid = 1'b1; fif.req_pc = 64'd112;
    #1 chk("idle_req_ready", 128'(fif.req_ready), 128'(0));
    step();
    chk("idle_rsp_valid", 128'(fif.rsp_valid), 128'(0));
    load_start = 1'b1; load_addr = 64'd112;
    step();
    load_start = 1'b0;
    chk("load_run", 128'(run), 128'(0));
    #1 chk("load_req_ready", 128'(fif.req_ready), 128'(0));
    fif.req_valid = 1'b0;

    for (int i = 0; i < 30; i++)
      push_byte(112 + i, (i < 10) ? prog[i] : 8'((112 + i) * 7 + 3));

    // load_start with a concurrent byte: the byte must be discarded
    load_start = 1'b1; load_addr = 64'd2038; load_valid = 1'b1; load_byte = 8'hEE;
    step();
    load_start = 1'b0; load_valid = 1'b0;
    for (int i = 0; i < 8; i++) push_byte(2038 + i, 8'(2038 + i) ^ 8'h5A);

    // Overflow past the top of memory
    load_start = 1'b1; load_addr = 64'd2046;
    step();
    load_start = 1'b0;
    push_byte(2046, 8'hC1); chk("ovf_err_b1", 128'(load_error), 128'(0));
    push_byte(2047, 8'hC2); chk("ovf_err_b2", 128'(load_error), 128'(0));
    push_byte(2048, 8'hC3); chk("ovf_err_b3", 128'(load_error), 128'(1));
    push_byte(2049, 8'hC4); chk("ovf_err_b4", 128'(load_error), 128'(1));
    load_start = 1'b1; load_addr = 64'd0;
    step();
    load_start = 1'b0;
    chk("ovf_err_clear", 128'(load_error), 128'(0));
    load_done = 1'b1;
    step();
    load_done = 1'b0;
    chk("enter_run", 128'(run), 128'(1));

    vecs[0] = '{64'd112, 1'b0, 8'h30, 72'hF80400000000000000};
    vecs[1] = '{64'd122, 1'b0, model[122], model_rest(122)};
    vecs[2] = '{64'd116, 1'b0, model[116], model_rest(116)};
    vecs[3] = '{64'd2038, 1'b0, model[2038], model_rest(2038)};
    vecs[4] = '{64'd2039, 1'b1, 8'h00, '0};
    vecs[5] = '{64'd132, 1'b0, model[132], model_rest(132)};
    vecs[6] = '{64'hFFFF_FFFF_FFFF_FFFF, 1'b1, 8'h00, '0};
    vecs[7] = '{64'd2048, 1'b1, 8'h00, '0};
    vecs[8] = '{64'h1_0000_0070, 1'b1, 8'h00, '0};

    // Back-to-back fetches, one response per edge
    fif.rsp_ready = 1'b1;
    for (int v = 0; v < 9; v++) begin
      fif.req_valid = 1'b1; fif.req_pc = vecs[v].pc;
      #1 chk($sformatf("vec%0d_req_ready", v), 128'(fif.req_ready), 128'(1));
      step();
      chk_rsp($sformatf("vec%0d", v), vecs[v].exp_err, vecs[v].exp_b0, vecs[v].exp_rest);
    end
    fif.req_valid = 1'b0;
    step();
    chk("drain_rsp_valid", 128'(fif.rsp_valid), 128'(0));

    // Stall: response held, no accept until rsp_ready
    fif.rsp_ready = 1'b0; fif.req_valid = 1'b1; fif.req_pc = 64'd122;
    step();
    fif.req_pc = 64'd132;
    for (int k = 0; k < 3; k++) begin
      #1 chk($sformatf("stall%0d_req_ready", k), 128'(fif.req_ready), 128'(0));
      chk_rsp($sformatf("stall%0d", k), 1'b0, model[122], model_rest(122));
      step();
    end
    fif.rsp_ready = 1'b1;
    #1 chk("unstall_req_ready", 128'(fif.req_ready), 128'(1));
    step();
    chk_rsp("unstall", 1'b0, model[132], model_rest(132));
    fif.req_valid = 1'b0;
    step();

    // load_start in RUN flushes the pending response
    fif.rsp_ready = 1'b0; fif.req_valid = 1'b1; fif.req_pc = 64'd112;
    step();
    fif.req_valid = 1'b0;
    chk("gate_rsp_valid", 128'(fif.rsp_valid), 128'(1));
    load_start = 1'b1; load_addr = 64'd0;
    step();
    load_start = 1'b0;
    chk("gate_flush", 128'(fif.rsp_valid), 128'(0));
    chk("gate_run",   128'(run),           128'(0));
    load_done = 1'b1;
    step();
    load_done = 1'b0;

    // Reset mid-load clears the sticky error
    load_start = 1'b1; load_addr = 64'd2048;
    step();
    load_start = 1'b0;
    push_byte(2048, 8'h77);
    chk("rl_load_err", 128'(load_error), 128'(1));
    rst = 1'b1;
    step();
    rst = 1'b0;
    chk("rl_load_err_rst", 128'(load_error), 128'(0));
    chk("rl_run_rst",      128'(run),        128'(0));

    // Reset with a pending error response drops it
    load_start = 1'b1; step(); load_start = 1'b0;
    load_done = 1'b1; step(); load_done = 1'b0;
    fif.req_valid = 1'b1; fif.req_pc = 64'd2039;
    step();
    fif.req_valid = 1'b0;
    chk("rf_rsp_error", 128'(fif.rsp_error), 128'(1));
    rst = 1'b1;
    step();
    rst = 1'b0;
    chk("rf_rsp_valid", 128'(fif.rsp_valid), 128'(0));
    chk("rf_rsp_error_rst", 128'(fif.rsp_error), 128'(0));
    chk("rf_run", 128'(run), 128'(0));

    // Memory survives reset
    load_start = 1'b1; step(); load_start = 1'b0;
    load_done = 1'b1; step(); load_done = 1'b0;
    fif.rsp_ready = 1'b1; fif.req_valid = 1'b1; fif.req_pc = 64'd112;
    step();
    fif.req_valid = 1'b0;
    chk_rsp("persist", 1'b0, 8'h30, 72'hF80400000000000000);
    step();

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
